// File: rtl/mem_access_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_access_arbiter.
// The arbiter uses the slave modport; the requesters/memory side uses master.
interface mem_access_arbiter_if #(
  parameter int W  = 32,
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [W-1:0]  dm_wdata;
  logic          dm_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic          mdr_load;
  logic [W-1:0]  rdata_out;
  logic          owner;
  logic          busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_done, dm_done, mem_en, mem_we, mem_addr, mem_wdata,
           mdr_load, rdata_out, owner, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_done, dm_done, mem_en, mem_we, mem_addr, mem_wdata,
           mdr_load, rdata_out, owner, busy
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin fetch/data arbiter for the shared memory port with fixed-latency access.
// Optional ARB_STATS_EN adds saturating per-requester grant counters.
module mem_access_arbiter #(
  parameter int W   = 32,
  parameter int AW  = 32,
  parameter int LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_access_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          if_grant_cnt,
  output logic [15:0]          dm_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state, state_n;
  logic [3:0]    cnt;
  logic          grant, grant_dm;
  logic          last_grant;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [W-1:0]  wdata_q;
  logic [W-1:0]  rdata_q;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    grant_dm = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          grant    = 1'b1;
          grant_dm = bus.dm_req && (!bus.if_req || !last_grant);
          state_n  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt == '0) state_n = S_COMPLETE;
      end
      S_COMPLETE: state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else if (grant) begin
      cnt        <= CNT_INIT;
      last_grant <= grant_dm;
      owner_q    <= grant_dm;
      we_q       <= grant_dm && bus.dm_we;
      addr_q     <= grant_dm ? bus.dm_addr : bus.if_addr;
      wdata_q    <= grant_dm ? bus.dm_wdata : '0;
    end else if (state == S_ACCESS) begin
      if (cnt == '0) begin
        if (!we_q) rdata_q <= bus.mem_rdata;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      if_grant_cnt <= '0;
      dm_grant_cnt <= '0;
    end else if (grant) begin
      if (!grant_dm && if_grant_cnt != '1) if_grant_cnt <= if_grant_cnt + 16'd1;
      if (grant_dm && dm_grant_cnt != '1)  dm_grant_cnt <= dm_grant_cnt + 16'd1;
    end
  end
`endif

  assign bus.mem_en    = (state == S_ACCESS);
  assign bus.mem_we    = (state == S_ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = (state == S_COMPLETE) && !owner_q;
  assign bus.dm_done   = (state == S_COMPLETE) && owner_q;
  assign bus.mdr_load  = (state == S_COMPLETE) && !we_q;
  assign bus.rdata_out = rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state == S_ACCESS) || (state == S_COMPLETE);

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Sequencing controller for the multicycle CPU's single shared memory port. It arbitrates between the instruction-fetch requester and the data (load/store) requester and runs the fixed-latency memory access. It generates the one-cycle load strobe for the memory data register, then signals completion to the winning requester. It sits between the control unit's fetch/memory states and the memory plus memory data register.

Parameters:
W, 32, data width (matches memory data register width)
AW, 32, address width
LAT, 2, memory access latency in cycles; legal range 1..15

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
if_req  input  1  instruction-fetch request, level, held until if_done
if_addr  input  AW  fetch address
if_done  output  1  one-cycle pulse, fetch access complete
dm_req  input  1  data request, level, held until dm_done
dm_we  input  1  1 = store, 0 = load
dm_addr  input  AW  data address
dm_wdata  input  W  store data
dm_done  output  1  one-cycle pulse, data access complete
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  W  memory write data
mem_rdata  input  W  memory read data, valid in final ACCESS cycle
mdr_load  output  1  one-cycle strobe: capture rdata_out into memory data register
rdata_out  output  W  read data latched from mem_rdata
owner  output  1  0 = fetch, 1 = data; owner of current/last access
busy  output  1  high in ACCESS and COMPLETE

Behaviour:
- States: IDLE, ACCESS, COMPLETE; registered 2-bit state. Down-counter cnt is 4 bits.
- Reset values: state=IDLE, all outputs 0, rdata_out=0, owner=0, last_grant=1 (data). With this value, fetch wins the first tie.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester not equal to last_grant (round-robin).
  - On grant: latch addr, we and wdata into mem_* registers (fetch grant forces we=0). Set owner and last_grant, cnt=LAT-1, go to ACCESS.
- ACCESS:
  - mem_en=1. mem_we = latched we. mem_addr/mem_wdata held stable for all LAT cycles.
  - cnt decrements each cycle. When cnt==0: if read, latch rdata_out <= mem_rdata; go to COMPLETE.
- COMPLETE:
  - mem_en=0, mem_we=0.
  - Pulse if_done or dm_done per owner for exactly one cycle.
  - mdr_load=1 for reads only (all fetches, and loads with dm_we=0). mdr_load=0 for stores.
  - Return to IDLE.
- Latency: request sampled in IDLE at edge N. ACCESS occupies cycles N+1..N+LAT. done/mdr_load are high in cycle N+LAT+1. Earliest next grant is at the edge ending the IDLE cycle N+LAT+2, so back-to-back accesses are spaced LAT+2 cycles apart.
- Requests are not re-sampled outside IDLE. A requester dropping req mid-access still receives its done pulse; the access is never aborted.
- A request still high in the IDLE cycle after done is treated as a new request. Requesters must drop req on seeing done.
- A requester with req high waits at most one access (round-robin guarantee).
- Reset mid-access: next state is IDLE, all strobes 0, no done pulse, no mdr_load. last_grant returns to 1.
- Address/data inputs changing during ACCESS have no effect on mem_* outputs.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds outputs if_grant_cnt [15:0] and dm_grant_cnt [15:0].
  - Each counter increments on every grant to its requester.
  - Each saturates at 16'hFFFF and clears on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LAT=2, reset held 3 cycles, then released -> all outputs 0, state IDLE; reset while in ACCESS -> no done, next cycle IDLE.
- if_req=1, if_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en high 2 cycles with mem_addr=0x100. Then if_done=1, mdr_load=1 and rdata_out=0xDEADBEEF in cycle 3 after grant.
- dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0x12345678 -> mem_we=1 for 2 cycles, then dm_done=1 with mdr_load=0.
- if_req and dm_req both held from reset -> grant order fetch, data, fetch, data. Each done is spaced LAT+2=4 cycles apart.
- dm_req dropped during ACCESS and dm_addr changed -> mem_addr unchanged, dm_done still pulses once.
- ARB_STATS_EN defined, 70000 fetch grants -> if_grant_cnt=0xFFFF (saturated), dm_grant_cnt=0.
